datarate_ctrl: RTL and testbench

- Frame-phase sequencer for the CAN FD bit-rate switch.
- Tracks frame progress from single-cycle field strobes issued by the bit-stream decoder. Drives the edl/brs/brsStop controls and selects which sample-point pulse (nominal or data-phase) goes to the bit-timing consumers.
- Sits between the frame decoder and the bit-timing/sampling logic.
- Supervises the fast data phase with a bit counter and a timeout.

---
 rtl/datarate_ctrl_if.sv | 31 +++
 rtl/datarate_ctrl.sv | 131 +++++++++++++
 tb/tb_datarate_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/datarate_ctrl_if.sv
// rtl/datarate_ctrl_if.sv - decoder strobes in, rate-switch controls and selected sample pulse out
interface datarate_ctrl_if;
  logic samplePoint;
  logic samplePointFD;
  logic frameStart;
  logic fdfValid;
  logic fdfBit;
  logic brsValid;
  logic brsBit;
  logic crcDelimValid;
  logic frameEnd;
  logic busError;
  logic edl;
  logic brs;
  logic brsStop;
  logic samplePointOUT;
  logic fastPhase;
  logic timeoutErr;

  modport master (
    output samplePoint, samplePointFD, frameStart, fdfValid, fdfBit,
           brsValid, brsBit, crcDelimValid, frameEnd, busError,
    input  edl, brs, brsStop, samplePointOUT, fastPhase, timeoutErr
  );

  modport slave (
    input  samplePoint, samplePointFD, frameStart, fdfValid, fdfBit,
           brsValid, brsBit, crcDelimValid, frameEnd, busError,
    output edl, brs, brsStop, samplePointOUT, fastPhase, timeoutErr
  );
endinterface

// File: rtl/datarate_ctrl.sv
// rtl/datarate_ctrl.sv - CAN FD frame-phase sequencer selecting nominal/data sample pulses
// Define BRS_TIMEOUT_EN to force fall-back to nominal rate after MAX_FAST_BITS fast bits.
module datarate_ctrl #(
  parameter int CNT_W         = 10,
  parameter int MAX_FAST_BITS = 700
) (
  input  logic           clk,
  input  logic           reset,
  datarate_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ARB      = 3'd1;
  localparam logic [2:0] CLASSIC  = 3'd2;
  localparam logic [2:0] FD_CTRL  = 3'd3;
  localparam logic [2:0] FD_SLOW  = 3'd4;
  localparam logic [2:0] FAST     = 3'd5;
  localparam logic [2:0] NOM_TAIL = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FAST_BITS);

  logic [2:0]       state, stateNext;
  logic             edl, edlNext;
  logic             brs, brsNext;
  logic             brsStop, brsStopNext;
  logic [CNT_W-1:0] counter, counterNext;
  logic             fastPhase;
  logic             timeoutErr, timeoutNext;

  // Only the highest-priority event of a cycle is acted on.
  always_comb begin
    stateNext   = state;
    edlNext     = edl;
    brsNext     = brs;
    brsStopNext = brsStop;
    counterNext = counter;
    timeoutNext = 1'b0;

    if (bus.busError) begin
      if (state != IDLE) begin
        stateNext   = IDLE;
        edlNext     = 1'b0;
        brsNext     = 1'b0;
        brsStopNext = 1'b0;
        counterNext = '0;
      end
    end else if (bus.frameEnd || bus.frameStart) begin
      stateNext   = bus.frameEnd ? IDLE : ARB;
      edlNext     = 1'b0;
      brsNext     = 1'b0;
      brsStopNext = 1'b0;
      counterNext = '0;
    end else begin
      case (state)
        ARB: begin
          if (bus.fdfValid) begin
            if (bus.fdfBit) begin
              stateNext = FD_CTRL;
              edlNext   = 1'b1;
            end else begin
              stateNext = CLASSIC;
            end
          end
        end
        FD_CTRL: begin
          if (bus.brsValid) begin
            if (bus.brsBit) begin
              stateNext   = FAST;
              brsNext     = 1'b1;
              counterNext = '0;
            end else begin
              stateNext = FD_SLOW;
            end
          end
        end
        FD_SLOW: begin
          if (bus.crcDelimValid) stateNext = NOM_TAIL;
        end
        FAST: begin
          // A fast sample coinciding with the CRC delimiter is still counted.
          if (bus.samplePointFD && counter != CNT_MAX) counterNext = counter + CNT_W'(1);
          if (bus.crcDelimValid) begin
            stateNext   = NOM_TAIL;
            brsStopNext = 1'b1;
          end
`ifdef BRS_TIMEOUT_EN
          else if (bus.samplePointFD && counter == CNT_MAX) begin
            stateNext   = NOM_TAIL;
            brsStopNext = 1'b1;
            timeoutNext = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      edl        <= 1'b0;
      brs        <= 1'b0;
      brsStop    <= 1'b0;
      counter    <= '0;
      fastPhase  <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= stateNext;
      edl        <= edlNext;
      brs        <= brsNext;
      brsStop    <= brsStopNext;
      counter    <= counterNext;
      fastPhase  <= edlNext & brsNext & ~brsStopNext;
      timeoutErr <= timeoutNext;
    end
  end

  // Selection follows the registered phase, so the switch cycle keeps the old source.
  assign bus.samplePointOUT = fastPhase ? bus.samplePointFD : bus.samplePoint;
  assign bus.edl            = edl;
  assign bus.brs            = brs;
  assign bus.brsStop        = brsStop;
  assign bus.fastPhase      = fastPhase;
`ifdef BRS_TIMEOUT_EN
  assign bus.timeoutErr     = timeoutErr;
`else
  assign bus.timeoutErr     = 1'b0;
`endif

endmodule

// File: tb/tb_datarate_ctrl.sv
// tb/tb_datarate_ctrl.sv - directed and randomized check of datarate_ctrl against a frame-progress model
module tb_datarate_ctrl;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  datarate_ctrl_if drIf ();

  datarate_ctrl #(.CNT_W(10), .MAX_FAST_BITS(MAXB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (drIf.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 awaiting FDF, 2 awaiting BRS, 3 data field, 4 tail/classic hold.
  int phase = 0;
  int mCnt = 0;
  bit mEdl = 0, mBrs = 0, mStop = 0, mTo = 0;

  task automatic checkVal(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mFast();
    return mEdl && mBrs && !mStop;
  endfunction

  task automatic modelClear();
    mEdl = 0; mBrs = 0; mStop = 0; mCnt = 0;
  endtask

  task automatic modelStep();
    bit timeout;
    mTo = 0;
    if (!reset) begin
      modelClear(); phase = 0;
    end else if (drIf.busError) begin
      if (phase != 0) begin modelClear(); phase = 0; end
    end else if (drIf.frameEnd) begin
      modelClear(); phase = 0;
    end else if (drIf.frameStart) begin
      modelClear(); phase = 1;
    end else begin
      case (phase)
        1: if (drIf.fdfValid) begin
             if (drIf.fdfBit) begin mEdl = 1; phase = 2; end
             else phase = 4;
           end
        2: if (drIf.brsValid) begin mBrs = drIf.brsBit; mCnt = 0; phase = 3; end
        3: begin
`ifdef BRS_TIMEOUT_EN
             timeout = mBrs && drIf.samplePointFD && mCnt == MAXB;
`else
             timeout = 0;
`endif
             if (mBrs && drIf.samplePointFD && mCnt < MAXB) mCnt++;
             if (drIf.crcDelimValid) begin mStop = mBrs; phase = 4; end
             else if (timeout) begin mStop = 1; mTo = 1; phase = 4; end
           end
        default: ;
      endcase
    end
  endtask

  task automatic clearInputs();
    drIf.samplePoint = 0; drIf.samplePointFD = 0; drIf.frameStart = 0;
    drIf.fdfValid = 0; drIf.fdfBit = 0; drIf.brsValid = 0; drIf.brsBit = 0;
    drIf.crcDelimValid = 0; drIf.frameEnd = 0; drIf.busError = 0;
  endtask

  // Inputs are set just after a rising edge; outputs are compared on the falling edge.
  task automatic tick();
    @(negedge clk);
    checkVal("samplePointOUT", drIf.samplePointOUT, mFast() ? drIf.samplePointFD : drIf.samplePoint);
    checkVal("edl", drIf.edl, mEdl);
    checkVal("brs", drIf.brs, mBrs);
    checkVal("brsStop", drIf.brsStop, mStop);
    checkVal("fastPhase", drIf.fastPhase, mFast());
    checkVal("timeoutErr", drIf.timeoutErr, mTo);
    @(posedge clk);
    modelStep();
    #1;
    clearInputs();
    reset = 1;
  endtask

  task automatic enterFast();
    drIf.frameStart = 1; tick();
    drIf.fdfValid = 1; drIf.fdfBit = 1; tick();
    drIf.brsValid = 1; drIf.brsBit = 1; tick();
  endtask

  task automatic fastBits(input int n, input bit crcOnLast);
    for (int i = 0; i < n; i++) begin
      drIf.samplePointFD = 1;
      drIf.samplePoint = 1'($urandom_range(1));
      if (crcOnLast && i == n - 1) drIf.crcDelimValid = 1;
      tick();
    end
  endtask

  initial begin
    clearInputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    checkVal("rst_edl", drIf.edl, 1'b0);
    checkVal("rst_fastPhase", drIf.fastPhase, 1'b0);

    // Classic frame
    drIf.frameStart = 1; tick();
    drIf.fdfValid = 1; drIf.fdfBit = 0; tick();
    for (int i = 0; i < 4; i++) begin drIf.samplePoint = 1'(i & 1); drIf.samplePointFD = 1'(~i & 1); tick(); end
    checkVal("classic_edl", drIf.edl, 1'b0);
    drIf.frameEnd = 1; tick();

    // FD frame with bit-rate switch
    drIf.frameStart = 1; tick();
    drIf.fdfValid = 1; drIf.fdfBit = 1; tick();
    checkVal("fd_edl", drIf.edl, 1'b1);
    drIf.brsValid = 1; drIf.brsBit = 1; tick();
    checkVal("fd_brs", drIf.brs, 1'b1);
    checkVal("fd_fastPhase", drIf.fastPhase, 1'b1);
    fastBits(20, 1'b0);
    drIf.crcDelimValid = 1; drIf.samplePointFD = 1; tick();
    checkVal("fd_brsStop", drIf.brsStop, 1'b1);
    checkVal("fd_fastPhase_off", drIf.fastPhase, 1'b0);
    drIf.samplePoint = 1; tick();
    drIf.frameEnd = 1; tick();
    checkVal("fd_end_edl", drIf.edl, 1'b0);
    checkVal("fd_end_brsStop", drIf.brsStop, 1'b0);

    // FD frame without switch
    drIf.frameStart = 1; tick();
    drIf.fdfValid = 1; drIf.fdfBit = 1; tick();
    drIf.brsValid = 1; drIf.brsBit = 0; tick();
    checkVal("slow_brs", drIf.brs, 1'b0);
    fastBits(3, 1'b0);
    drIf.crcDelimValid = 1; tick();
    checkVal("slow_brsStop", drIf.brsStop, 1'b0);
    drIf.frameEnd = 1; tick();

    // Bus error in the fast phase, alone and together with a new SOF
    enterFast();
    fastBits(5, 1'b0);
    drIf.busError = 1; tick();
    checkVal("err_edl", drIf.edl, 1'b0);
    checkVal("err_fastPhase", drIf.fastPhase, 1'b0);
    enterFast();
    drIf.busError = 1; drIf.frameStart = 1; tick();
    drIf.fdfValid = 1; drIf.fdfBit = 1; tick();
    checkVal("err_sof_edl", drIf.edl, 1'b0);

    // Fast-bit budget exhausted, then exhausted together with the CRC delimiter
    enterFast();
    fastBits(MAXB + 1, 1'b0);
`ifdef BRS_TIMEOUT_EN
    checkVal("to_brsStop", drIf.brsStop, 1'b1);
    checkVal("to_pulse", drIf.timeoutErr, 1'b1);
    tick();
    checkVal("to_pulse_end", drIf.timeoutErr, 1'b0);
`else
    checkVal("to_still_fast", drIf.fastPhase, 1'b1);
    checkVal("to_none", drIf.timeoutErr, 1'b0);
`endif
    drIf.frameEnd = 1; tick();
    enterFast();
    fastBits(MAXB + 1, 1'b1);
    checkVal("to_crc_brsStop", drIf.brsStop, 1'b1);
    checkVal("to_crc_none", drIf.timeoutErr, 1'b0);
    drIf.frameEnd = 1; tick();

    // Reset in the fast phase; a stray BRS afterwards is ignored
    enterFast();
    fastBits(3, 1'b0);
    reset = 0; tick();
    checkVal("rst_mid_brs", drIf.brs, 1'b0);
    checkVal("rst_mid_fast", drIf.fastPhase, 1'b0);
    drIf.brsValid = 1; drIf.brsBit = 1; tick();
    checkVal("rst_stray_brs", drIf.brs, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drIf.samplePoint   = ($urandom_range(99) < 25);
      drIf.samplePointFD = ($urandom_range(99) < 50);
      drIf.frameStart    = ($urandom_range(99) < 3);
      drIf.fdfValid      = ($urandom_range(99) < 20);
      drIf.fdfBit        = ($urandom_range(99) < 70);
      drIf.brsValid      = ($urandom_range(99) < 20);
      drIf.brsBit        = ($urandom_range(99) < 70);
      drIf.crcDelimValid = ($urandom_range(99) < 4);
      drIf.frameEnd      = ($urandom_range(99) < 2);
      drIf.busError      = ($urandom_range(99) < 1);
      if (drIf.busError && phase == 0) drIf.frameStart = 0;
      reset = ($urandom_range(299) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
